// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared encodings and constants for the memory controller.
// No ports. Holds FSM state encoding, access-width (memcnf) codes, bus widths,
// default UART address / fetch length, and a memcnf -> byte-count helper.
package mem_ctrl_pkg;

  localparam int MemDataBus = 32;
  localparam int InstBus    = 32;
  localparam int NUM_LANES  = MemDataBus / 8;
  localparam int LANE_W     = 2;

  localparam logic [31:0] IO_ADDR_DEFAULT    = 32'h0003_0000;
  localparam int          ICACHE_LEN_DEFAULT = 4;

  localparam logic [1:0] MEMCNF_NONE = 2'b00;
  localparam logic [1:0] MEMCNF_BYTE = 2'b01;
  localparam logic [1:0] MEMCNF_HALF = 2'b10;
  localparam logic [1:0] MEMCNF_WORD = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_DONE} state_e;
  typedef enum logic {OWN_D, OWN_I} owner_e;

  // Number of byte transfers for a dcache access width.
  function automatic logic [2:0] memcnf_len(input logic [1:0] cnf);
    case (cnf)
      MEMCNF_BYTE: return 3'd1;
      MEMCNF_HALF: return 3'd2;
      MEMCNF_WORD: return 3'd4;
      default:     return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_byte_lane.sv
// mem_byte_lane: combinational byte-lane steering.
//   wr_lane/wdata -> dout     : picks byte wr_lane of the write word
//   rd_lane/rbuf/din -> rbuf_ins : rbuf with byte rd_lane replaced by din
module mem_byte_lane
  import mem_ctrl_pkg::*;
(
  input  logic [LANE_W-1:0]     wr_lane,
  input  logic [MemDataBus-1:0] wdata,
  output logic [7:0]            dout,
  input  logic [LANE_W-1:0]     rd_lane,
  input  logic [MemDataBus-1:0] rbuf,
  input  logic [7:0]            din,
  output logic [MemDataBus-1:0] rbuf_ins
);

  logic [NUM_LANES-1:0][7:0] wl, rl, il;

  assign wl       = wdata;
  assign rl       = rbuf;
  assign dout     = wl[wr_lane];
  assign rbuf_ins = il;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign il[l] = (rd_lane == LANE_W'(l)) ? din : rl[l];
  end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates dcache/icache onto a byte-wide single-port RAM/IO bus.
//   clk, rst (async, active-high)
//   d_*    : dcache request (held until done pulse), read data + pulses
//   i_*    : icache fetch request, flush, fetch data + pulse
//   io_buffer_full : stalls dcache writes to IO_ADDR
//   mem_*  : byte bus; mem_din is valid the cycle after its address
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [31:0] IO_ADDR    = IO_ADDR_DEFAULT,
  parameter int          ICACHE_LEN = ICACHE_LEN_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  d_data_needed,
  input  logic [31:0]           d_addr,
  input  logic                  d_wr,
  input  logic [1:0]            d_memcnf,
  input  logic [MemDataBus-1:0] d_data_write,
  output logic                  d_data_available,
  output logic [MemDataBus-1:0] d_data,
  output logic                  d_addr_needed,
  input  logic                  i_needed,
  input  logic [31:0]           i_addr,
  input  logic                  i_flush,
  output logic                  i_available,
  output logic [InstBus-1:0]    i_data,
  input  logic                  io_buffer_full,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [31:0]           mem_a,
  output logic                  mem_wr
);

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  logic [2:0]            k_q, k_d, len_q, len_d;
  logic [31:0]           addr_q, addr_d;
  logic [MemDataBus-1:0] wdata_q, wdata_d, rbuf_q, rbuf_d;
  logic [MemDataBus-1:0] d_data_q, d_data_d;
  logic [InstBus-1:0]    i_data_q, i_data_d;
  logic                  d_avail_q, d_avail_d, d_done_q, d_done_d, i_avail_q, i_avail_d;

  logic                  d_ok, i_ok, rd_last, wr_last, flush_hit;
  logic [7:0]            lane_dout;
  logic [MemDataBus-1:0] rbuf_ins;

  // A UART write while the buffer is full is simply not accepted; the held
  // request retries itself every IDLE cycle.
  assign d_ok      = d_data_needed && (d_memcnf != MEMCNF_NONE) &&
                     !(d_wr && (d_addr == IO_ADDR) && io_buffer_full);
  assign i_ok      = i_needed && !i_flush;
  assign rd_last   = (k_q == len_q);
  assign wr_last   = (k_q == len_q - 3'd1);
  assign flush_hit = (owner_q == OWN_I) && i_flush;

  mem_byte_lane u_lane (
    .wr_lane  (k_q[1:0]),
    .wdata    (wdata_q),
    .dout     (lane_dout),
    .rd_lane  (k_q[1:0] - 2'd1),  // byte from address k-1 arrives at step k
    .rbuf     (rbuf_q),
    .din      (mem_din),
    .rbuf_ins (rbuf_ins)
  );

  // State register and datapath flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_D;
      k_q       <= '0;
      len_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rbuf_q    <= '0;
      d_data_q  <= '0;
      i_data_q  <= '0;
      d_avail_q <= 1'b0;
      d_done_q  <= 1'b0;
      i_avail_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      k_q       <= k_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rbuf_q    <= rbuf_d;
      d_data_q  <= d_data_d;
      i_data_q  <= i_data_d;
      d_avail_q <= d_avail_d;
      d_done_q  <= d_done_d;
      i_avail_q <= i_avail_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (d_ok)      state_d = d_wr ? ST_WRITE : ST_READ;
        else if (i_ok) state_d = ST_READ;
      end
      ST_READ: begin
        if (flush_hit)    state_d = ST_IDLE;
        else if (rd_last) state_d = ST_DONE;
      end
      ST_WRITE: if (wr_last) state_d = ST_DONE;
      default:  state_d = ST_IDLE;  // DONE: single cooldown cycle
    endcase
  end

  // Datapath next values
  always_comb begin
    owner_d   = owner_q;
    k_d       = k_q;
    len_d     = len_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rbuf_d    = rbuf_q;
    d_data_d  = d_data_q;
    i_data_d  = i_data_q;
    d_avail_d = 1'b0;
    d_done_d  = 1'b0;
    i_avail_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        k_d    = '0;
        rbuf_d = '0;  // unused upper lanes of short reads come back as zero
        if (d_ok) begin
          owner_d = OWN_D;
          addr_d  = d_addr;
          wdata_d = d_data_write;
          len_d   = memcnf_len(d_memcnf);
        end else if (i_ok) begin
          owner_d = OWN_I;
          addr_d  = i_addr;
          len_d   = 3'(ICACHE_LEN);
        end
      end
      ST_READ: begin
        if (!flush_hit) begin
          if (k_q != 3'd0) rbuf_d = rbuf_ins;
          if (rd_last) begin
            if (owner_q == OWN_D) begin
              d_data_d  = rbuf_ins;
              d_avail_d = 1'b1;
            end else begin
              i_data_d  = rbuf_ins;
              i_avail_d = 1'b1;
            end
          end else begin
            k_d = k_q + 3'd1;
          end
        end
      end
      ST_WRITE: begin
        if (wr_last) d_done_d = 1'b1;
        else         k_d = k_q + 3'd1;
      end
      default: ;
    endcase
  end

  // Bus outputs
  always_comb begin
    mem_a    = '0;
    mem_wr   = 1'b0;
    mem_dout = '0;
    case (state_q)
      ST_READ: if (k_q < len_q) mem_a = addr_q + 32'(k_q);
      ST_WRITE: begin
        mem_a    = addr_q + 32'(k_q);
        mem_wr   = 1'b1;
        mem_dout = lane_dout;
      end
      default: ;
    endcase
  end

  assign d_data_available = d_avail_q;
  assign d_addr_needed    = d_done_q;
  assign d_data           = d_data_q;
  assign i_available      = i_avail_q;
  assign i_data           = i_data_q;

endmodule
